// File: rtl/cam_pkg.sv
// Shared types for the cam_alloc tag CAM.
//   cam_state_e  : control FSM states (idle / sequential flush)
//   cam_result_t : lookup result (found flag, entry index, entry data).
//                  The fields are sized for the widest supported build.
//                  Each instance uses only the low bits it needs.
package cam_pkg;

   localparam int CAM_IDX_MAX  = 16;
   localparam int CAM_DATA_MAX = 64;

   typedef enum logic {
      CAM_IDLE  = 1'b0,
      CAM_FLUSH = 1'b1
   } cam_state_e;

   typedef struct packed {
      logic                    found;
      logic [CAM_IDX_MAX-1:0]  index;
      logic [CAM_DATA_MAX-1:0] data;
   } cam_result_t;

endpackage

// File: rtl/cam_alloc_if.sv
// Request/response bundle for cam_alloc.
//   master : requester side. It drives read, write_ (active-low), inval,
//            flush, check_tag, new_tag and wdata.
//   slave  : CAM side. It drives the lookup result (data, found_it,
//            hit_index, rvalid), the occupancy flags (full, empty, count),
//            busy and wr_drop.
interface cam_alloc_if #(
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = 2
);
   logic                 read;
   logic                 write_;
   logic                 inval;
   logic                 flush;
   logic [TAG_SZ-1:0]    check_tag;
   logic [TAG_SZ-1:0]    new_tag;
   logic [BITS-1:0]      wdata;
   logic [BITS-1:0]      data;
   logic                 found_it;
   logic [ADDR_LEFT:0]   hit_index;
   logic                 rvalid;
   logic                 full;
   logic                 empty;
   logic [ADDR_LEFT+1:0] count;
   logic                 busy;
   logic                 wr_drop;

   modport master (
      output read, write_, inval, flush, check_tag, new_tag, wdata,
      input  data, found_it, hit_index, rvalid, full, empty, count, busy, wr_drop
   );

   modport slave (
      input  read, write_, inval, flush, check_tag, new_tag, wdata,
      output data, found_it, hit_index, rvalid, full, empty, count, busy, wr_drop
   );
endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder.
//   vec : request vector
//   any : at least one bit of vec is set
//   idx : index of the lowest set bit (0 when any=0)
module cam_prio_enc #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic          any,
   output logic [IW-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            any = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/cam_alloc.sv
// cam_alloc: small fully-associative tag CAM with allocate-on-write.
//   clk, rst : rising-edge clock and synchronous active-high reset
//   bus      : cam_alloc_if.slave. It carries the requests (read, write_,
//              inval, flush, tags, wdata) and the responses (registered
//              lookup result, rvalid, full/empty/count, busy, wr_drop).
// Lookup has a latency of one cycle and sees the contents from before any
// write or inval in the same cycle. A write updates a matching entry in
// place. Otherwise it fills the lowest free entry. A flush clears one
// entry per cycle and ignores all requests while busy.
// Build option: define CAM_RR_EVICT_EN to replace a round-robin victim
// when a write misses on a full CAM. Without it, such a write is dropped
// and wr_drop pulses.
module cam_alloc
   import cam_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
   input logic        clk,
   input logic        rst,
   cam_alloc_if.slave bus
);

   localparam int IW = ADDR_LEFT + 1;
   localparam int CW = ADDR_LEFT + 2;

   function automatic logic [CW-1:0] popcount(input logic [WORDS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < WORDS; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   cam_state_e        state_q, state_d;
   logic [IW-1:0]     flush_ptr_q, flush_ptr_d;
   logic [WORDS-1:0]  valid_q, valid_d;
   logic [TAG_SZ-1:0] tag_q [WORDS];
   logic [BITS-1:0]   mem_q [WORDS];

   logic [WORDS-1:0]  look_match, wr_match, free_vec;
   logic              look_any, free_any, wr_hit;
   logic [IW-1:0]     look_idx, free_idx, new_idx;
   logic              rd_take, upd_en, new_en, drop_d;
   logic [CW-1:0]     count_d, count_q;
   logic              full_q, empty_q;

   cam_result_t       res_d, res_p1;
   logic              vld_p1, drop_p1;
   logic              unused_res_pad;

`ifdef CAM_RR_EVICT_EN
   logic [IW-1:0]     victim_q;
   logic              victim_adv;
`endif

   always_comb begin
      look_match = '0;
      wr_match   = '0;
      for (int i = 0; i < WORDS; i++) begin
         look_match[i] = valid_q[i] && (tag_q[i] == bus.check_tag);
         wr_match[i]   = valid_q[i] && (tag_q[i] == bus.new_tag);
      end
   end

   // A tag is only allocated when it misses, so at most one entry can match
   // new_tag. An in-place update therefore needs no encoder.
   assign wr_hit   = |wr_match;
   assign free_vec = ~valid_q;

   cam_prio_enc #(.N(WORDS), .IW(IW)) u_look_enc (
      .vec (look_match),
      .any (look_any),
      .idx (look_idx)
   );

   cam_prio_enc #(.N(WORDS), .IW(IW)) u_free_enc (
      .vec (free_vec),
      .any (free_any),
      .idx (free_idx)
   );

   always_comb begin
      state_d     = state_q;
      flush_ptr_d = flush_ptr_q;
      valid_d     = valid_q;
      rd_take     = 1'b0;
      upd_en      = 1'b0;
      new_en      = 1'b0;
      new_idx     = free_idx;
      drop_d      = 1'b0;
`ifdef CAM_RR_EVICT_EN
      victim_adv  = 1'b0;
`endif
      case (state_q)
         CAM_IDLE: begin
            rd_take = bus.read;
            if (bus.flush) begin
               state_d     = CAM_FLUSH;
               flush_ptr_d = '0;
            end else if (!bus.write_) begin
               if (wr_hit) begin
                  upd_en = 1'b1;
               end else if (free_any) begin
                  new_en = 1'b1;
               end else begin
`ifdef CAM_RR_EVICT_EN
                  new_en     = 1'b1;
                  new_idx    = victim_q;
                  victim_adv = 1'b1;
`else
                  drop_d     = 1'b1;
`endif
               end
               if (new_en) valid_d[new_idx] = 1'b1;
            end else if (bus.inval) begin
               valid_d = valid_q & ~look_match;
            end
         end
         CAM_FLUSH: begin
            valid_d[flush_ptr_q] = 1'b0;
            flush_ptr_d          = flush_ptr_q + IW'(1);
            if (flush_ptr_q == IW'(WORDS - 1)) state_d = CAM_IDLE;
         end
         default: state_d = CAM_IDLE;
      endcase
   end

   assign count_d = popcount(valid_d);

   always_comb begin
      res_d       = '0;
      res_d.found = look_any;
      res_d.index = CAM_IDX_MAX'(look_idx);
      if (look_any) res_d.data = CAM_DATA_MAX'(mem_q[look_idx]);
   end

   // ---- stage p1: registered state, occupancy flags and lookup result ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CAM_IDLE;
         flush_ptr_q <= '0;
         valid_q     <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         vld_p1      <= 1'b0;
         drop_p1     <= 1'b0;
         res_p1      <= '0;
      end else begin
         state_q     <= state_d;
         flush_ptr_q <= flush_ptr_d;
         valid_q     <= valid_d;
         count_q     <= count_d;
         full_q      <= (count_d == CW'(WORDS));
         empty_q     <= (count_d == '0);
         vld_p1      <= rd_take;
         drop_p1     <= drop_d;
         if (rd_take) res_p1 <= res_d;
      end
   end

   // Tag and data storage is not reset. The valid bits alone define the
   // contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WORDS; i++) begin
         if (upd_en && wr_match[i]) mem_q[i] <= bus.wdata;
         if (new_en && (new_idx == IW'(i))) begin
            tag_q[i] <= bus.new_tag;
            mem_q[i] <= bus.wdata;
         end
      end
   end

`ifdef CAM_RR_EVICT_EN
   // The victim pointer wraps naturally because WORDS is a power of two.
   always_ff @(posedge clk) begin
      if (rst)             victim_q <= '0;
      else if (victim_adv) victim_q <= victim_q + IW'(1);
   end
`endif

   assign bus.data      = res_p1.data[BITS-1:0];
   assign bus.found_it  = res_p1.found;
   assign bus.hit_index = res_p1.index[IW-1:0];
   assign bus.rvalid    = vld_p1;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;
   assign bus.busy      = (state_q == CAM_FLUSH);
   assign bus.wr_drop   = drop_p1;

   // The high bits of the shared result struct above BITS/IW are never read.
   assign unused_res_pad = ^res_p1;

endmodule

// File: tb/tb_cam_alloc.sv
// Testbench for cam_alloc.
// Directed scenarios and a randomized phase drive the CAM. A behavioural
// model (plain arrays and first-match searches) predicts every lookup
// result into a queue. A negedge monitor pops and compares each rvalid
// response. Occupancy, busy and wr_drop are compared after every cycle.
// The model follows CAM_RR_EVICT_EN in the same way as the design.
module tb_cam_alloc;

   localparam int WORDS     = 8;
   localparam int BITS      = 8;
   localparam int TAG_SZ    = 8;
   localparam int ADDR_LEFT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cam_alloc_if #(.BITS(BITS), .TAG_SZ(TAG_SZ), .ADDR_LEFT(ADDR_LEFT)) bus ();

   cam_alloc #(
      .WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ), .ADDR_LEFT(ADDR_LEFT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit found;
      int idx;
      int data;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit m_valid [WORDS];
   int m_tag   [WORDS];
   int m_data  [WORDS];
   int m_victim;
   int m_flush_left;
   bit m_drop;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < WORDS; i++) m_valid[i] = 1'b0;
      m_victim     = 0;
      m_flush_left = 0;
      m_drop       = 1'b0;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < WORDS; i++) if (m_valid[i]) n++;
      return n;
   endfunction

   function automatic exp_t model_lookup(int t);
      exp_t e;
      e.cyc = 0; e.found = 1'b0; e.idx = 0; e.data = 0;
      for (int i = 0; i < WORDS; i++) begin
         if (m_valid[i] && m_tag[i] == t) begin
            e.found = 1'b1; e.idx = i; e.data = m_data[i];
            return e;
         end
      end
      return e;
   endfunction

   function automatic void model_write(int t, int d);
      for (int i = 0; i < WORDS; i++) begin
         if (m_valid[i] && m_tag[i] == t) begin
            m_data[i] = d;
            return;
         end
      end
      for (int i = 0; i < WORDS; i++) begin
         if (!m_valid[i]) begin
            m_valid[i] = 1'b1; m_tag[i] = t; m_data[i] = d;
            return;
         end
      end
`ifdef CAM_RR_EVICT_EN
      m_valid[m_victim] = 1'b1; m_tag[m_victim] = t; m_data[m_victim] = d;
      m_victim = (m_victim + 1) % WORDS;
`else
      m_drop = 1'b1;
`endif
   endfunction

   task automatic check_status();
      int n = model_count();
      chk("count", int'(bus.count), n);
      chk("full", int'(bus.full), (n == WORDS) ? 1 : 0);
      chk("empty", int'(bus.empty), (n == 0) ? 1 : 0);
      chk("busy", int'(bus.busy), (m_flush_left > 0) ? 1 : 0);
      chk("wr_drop", int'(bus.wr_drop), int'(m_drop));
   endtask

   // One clock cycle of requests. Called at a negedge. It returns at the
   // next negedge after checking status.
   task automatic step(bit rd, bit wr_n, bit inv, bit fl, int ctag, int ntag, int wd);
      bus.read      = rd;
      bus.write_    = wr_n;
      bus.inval     = inv;
      bus.flush     = fl;
      bus.check_tag = TAG_SZ'(ctag);
      bus.new_tag   = TAG_SZ'(ntag);
      bus.wdata     = BITS'(wd);
      m_drop = 1'b0;
      if (m_flush_left > 0) begin
         m_valid[WORDS - m_flush_left] = 1'b0;
         m_flush_left--;
      end else begin
         if (rd) begin
            exp_t e = model_lookup(ctag);
            e.cyc = cyc + 1;
            q.push_back(e);
         end
         if (fl) m_flush_left = WORDS;
         else if (!wr_n) model_write(ntag, wd);
         else if (inv) begin
            for (int i = 0; i < WORDS; i++)
               if (m_valid[i] && m_tag[i] == ctag) m_valid[i] = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_status();
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic wr(int t, int d);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, t, d);
   endtask

   task automatic rd(int t);
      step(1'b1, 1'b1, 1'b0, 1'b0, t, 0, 0);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.read      = 1'b0;
      bus.write_    = 1'b1;
      bus.inval     = 1'b0;
      bus.flush     = 1'b0;
      bus.check_tag = '0;
      bus.new_tag   = '0;
      bus.wdata     = '0;
      q.delete();
      @(posedge clk);
      @(negedge clk);
      model_reset();
      chk("rst_rvalid", int'(bus.rvalid), 0);
      chk("rst_found_it", int'(bus.found_it), 0);
      chk("rst_hit_index", int'(bus.hit_index), 0);
      chk("rst_data", int'(bus.data), 0);
      check_status();
      rst = 1'b0;
   endtask

   // Lookup response monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rvalid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rvalid_unexpected: got rvalid=1, want 0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rd_latency", cyc, e.cyc);
               chk("found_it", int'(bus.found_it), int'(e.found));
               chk("hit_index", int'(bus.hit_index), e.idx);
               chk("data", int'(bus.data), e.data);
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            void'(q.pop_front());
            checks++;
            errors++;
            $display("FAIL rvalid_missing: got rvalid=0, want 1 (cycle %0d)", cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      do_reset();

      // Two writes, then a hit on the second entry
      wr(8'h11, 8'hA1);
      wr(8'h22, 8'hA2);
      rd(8'h22);
      idle();

      // In-place update keeps the count
      do_reset();
      wr(8'h33, 8'h01);
      wr(8'h33, 8'h02);
      rd(8'h33);
      idle();

      // A lookup in the same cycle as a write sees the old contents
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 8'h44, 8'h5A);
      rd(8'h44);
      idle();

      // Fill the CAM, then write a new tag while full
      do_reset();
      for (int i = 0; i < WORDS; i++) wr(8'h50 + i, 8'hC0 + i);
      wr(8'h99, 8'hEE);
      idle();
      rd(8'h50);
      rd(8'h99);
      rd(8'h57);
      idle();

      // Invalidate a hit, then one that misses
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h53, 0, 0);
      rd(8'h53);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 0, 0);
      idle();

      // Flush with five valid entries. Requests during busy are ignored.
      do_reset();
      for (int i = 0; i < 5; i++) wr(8'h60 + i, 8'h10 + i);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h62, 0, 0);
      for (int i = 0; i < WORDS; i++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'h60 + i, 8'h70 + i, i);
      rd(8'h61);
      idle();

      // Reset during the third cycle of a flush
      do_reset();
      for (int i = 0; i < 5; i++) wr(8'h80 + i, i);
      step(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
      idle();
      idle();
      do_reset();
      wr(8'h77, 8'h3C);
      rd(8'h77);
      idle();

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 600; n++) begin
         bit r_rd, r_wn, r_inv, r_fl;
         r_fl  = ($urandom_range(0, 99) < 3);
         r_wn  = ($urandom_range(0, 1) == 0);
         r_inv = ($urandom_range(0, 3) == 0);
         r_rd  = ($urandom_range(0, 1) == 1);
         step(r_rd, r_wn, r_inv, r_fl,
              8'h10 + $urandom_range(0, 11), 8'h10 + $urandom_range(0, 11),
              $urandom_range(0, 255));
      end
      idle();
      idle();
      chk("pending_lookups", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
